// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_pkg
//  Description : Shared definitions for the exhaustive gate sweep checker:
//                mode codes, FSM state encoding and the golden gate function.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_sweep_pkg;

    // Largest supported gate input count; the golden function works on
    // vectors zero-extended to this width.
    localparam int MAX_N_IN = 8;

    // Golden function selectors; codes 6 and 7 are reserved.
    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // True for the six defined gate functions.
    function automatic logic mode_valid(input logic [2:0] mode);
        return (mode <= MODE_XNOR);
    endfunction

    // Reduction of the low n_in bits of vec under the selected gate function.
    // With n_in == 1 the reductions degenerate to buffer / inverter.
    function automatic logic golden_gate(input logic [MAX_N_IN-1:0] vec,
                                         input int                  n_in,
                                         input logic [2:0]          mode);
        logic w_and;
        logic w_or;
        logic w_xor;
        logic w_res;
        w_and = 1'b1;
        w_or  = 1'b0;
        w_xor = 1'b0;
        for (int i = 0; i < MAX_N_IN; i++) begin
            if (i < n_in) begin
                w_and = w_and & vec[i];
                w_or  = w_or  | vec[i];
                w_xor = w_xor ^ vec[i];
            end
        end
        case (mode)
            MODE_AND:  w_res = w_and;
            MODE_OR:   w_res = w_or;
            MODE_NAND: w_res = ~w_and;
            MODE_NOR:  w_res = ~w_or;
            MODE_XOR:  w_res = w_xor;
            MODE_XNOR: w_res = ~w_xor;
            default:   w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_golden.sv
`default_nettype none
// ============================================================================
//  Module      : gate_golden_model
//  Description : Combinational golden reference for an N_IN-input primitive
//                gate, selected by mode. Reusable by other gate benches.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_golden_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] i_vec,
    input  logic [2:0]      i_mode,
    output logic            o_gold
);

    logic [MAX_N_IN-1:0] w_vec;

    // Zero-extend the vector and evaluate the shared golden function.
    always_comb begin
        w_vec             = '0;
        w_vec[N_IN-1:0]   = i_vec;
        o_gold            = golden_gate(w_vec, N_IN, i_mode);
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_checker
//  Description : Exhaustive stimulus engine for N_IN-input gate models. Drives
//                every input vector, holds it HOLD_CYCLES cycles, compares the
//                gate output with a golden function and reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_vld,
    output logic             mode_err
);

    // One spare bit on each counter so neither can wrap inside a sweep.
    localparam int                  c_hold_w    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_IN:0]      r_stim;
    logic [c_hold_w-1:0] r_hold;
    logic [2:0]         r_mode;
    logic [ERR_W-1:0]   r_err;
    logic [N_IN-1:0]    r_ffvec;
    logic               r_ffvld;
    logic               r_mode_err;

    logic               w_accept;
    logic               w_hold_last;
    logic               w_stim_last;
    logic               w_gold;

    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_hold_last = (r_hold == c_hold_last);
    assign w_stim_last = &r_stim[N_IN-1:0];

    gate_golden_model #(
        .N_IN (N_IN)
    ) u_golden (
        .i_vec  (r_stim[N_IN-1:0]),
        .i_mode (r_mode),
        .o_gold (w_gold)
    );

    // State register; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a reserved mode skips the sweep and finishes at once.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = mode_valid(mode) ? ST_DRIVE : ST_DONE;
                end
            end
            ST_DRIVE: begin
                if (w_hold_last) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_nxt = w_stim_last ? ST_DONE : ST_DRIVE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters and result registers; start only takes effect when not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim     <= '0;
            r_hold     <= '0;
            r_mode     <= '0;
            r_err      <= '0;
            r_ffvec    <= '0;
            r_ffvld    <= 1'b0;
            r_mode_err <= 1'b0;
        end else if (w_accept) begin
            r_stim     <= '0;
            r_hold     <= '0;
            r_mode     <= mode;
            r_err      <= '0;
            r_ffvec    <= '0;
            r_ffvld    <= 1'b0;
            r_mode_err <= ~mode_valid(mode);
        end else begin
            case (r_state)
                ST_DRIVE: begin
                    if (!w_hold_last) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (dut_out != w_gold) begin
                        if (r_err != '1) begin
                            r_err <= r_err + 1'b1;
                        end
                        if (!r_ffvld) begin
                            r_ffvec <= r_stim[N_IN-1:0];
                            r_ffvld <= 1'b1;
                        end
                    end
                    // The last vector stays on stim through DONE.
                    if (!w_stim_last) begin
                        r_stim <= r_stim + 1'b1;
                        r_hold <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim           = r_stim[N_IN-1:0];
    assign busy           = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && !r_mode_err && (r_err == '0);
    assign err_count      = r_err;
    assign first_fail_vec = r_ffvec;
    assign first_fail_vld = r_ffvld;
    assign mode_err       = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_sweep_checker
//  Description : Self-checking bench for gate_sweep_checker: vector table,
//                randomized gate responses against a parity/popcount model,
//                reset, ignored re-start and counter saturation sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic       dut_out;
    logic [1:0] stim;
    logic       busy, done, pass, first_fail_vld, mode_err;
    logic [7:0] err_count;
    logic [1:0] first_fail_vec;

    logic       start3;
    logic [2:0] mode3;
    logic       dut_out3;
    logic [2:0] stim3;
    logic       busy3, done3, pass3, first_fail_vld3, mode_err3;
    logic [1:0] err_count3;
    logic [2:0] first_fail_vec3;

    int n_cmp = 0;
    int n_bad = 0;

    // Gate-under-test model: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 table.
    int         gut_kind;
    logic [2:0] gut_mode;
    logic [3:0] resp;

    always #5 clk = ~clk;

    gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(10), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .dut_out(dut_out),
        .stim(stim), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_vec(first_fail_vec),
        .first_fail_vld(first_fail_vld), .mode_err(mode_err)
    );

    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(2), .ERR_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .dut_out(dut_out3),
        .stim(stim3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .first_fail_vec(first_fail_vec3),
        .first_fail_vld(first_fail_vld3), .mode_err(mode_err3)
    );

    // Reference gate from popcount: AND = all ones, OR = any one, XOR = odd.
    function automatic logic ref_gate(input int v, input int n, input logic [2:0] m);
        int ones;
        ones = $countones(v & ((1 << n) - 1));
        case (m)
            3'd0:    return ones == n;
            3'd1:    return ones != 0;
            3'd2:    return ones != n;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        case (gut_kind)
            0:       dut_out = ref_gate(int'(stim), 2, gut_mode);
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            default: dut_out = resp[stim];
        endcase
    end

    assign dut_out3 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one sweep on u_dut and compare every result output. With disturb,
    // start is re-pulsed and mode flipped part way through the sweep.
    task automatic run_sweep(input string tag, input logic [2:0] m, input int kind,
                             input bit disturb, input int e_err, input int e_vld,
                             input int e_vec, input int e_merr, input int e_lat);
        int lat;
        int last;
        int seq[$];
        bit valid;
        bit seq_ok;
        valid    = (m <= 3'd5);
        gut_kind = kind;
        gut_mode = m;
        mode     = m;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy_on_accept"}, int'(busy), int'(valid));
        lat  = 0;
        last = int'(stim);
        seq.push_back(last);
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (disturb && lat == 15) begin
                mode  = m ^ 3'd1;
                start = 1'b1;
            end
            if (disturb && lat == 16) start = 1'b0;
            if (!done && int'(stim) != last) begin
                last = int'(stim);
                seq.push_back(last);
            end
        end
        check({tag, ".latency"},   lat,                   e_lat);
        check({tag, ".done"},      int'(done),            1);
        check({tag, ".busy_off"},  int'(busy),            0);
        check({tag, ".err_count"}, int'(err_count),       e_err);
        check({tag, ".ff_vld"},    int'(first_fail_vld),  e_vld);
        check({tag, ".ff_vec"},    int'(first_fail_vec),  e_vec);
        check({tag, ".mode_err"},  int'(mode_err),        e_merr);
        check({tag, ".pass"},      int'(pass),            int'(e_merr == 0 && e_err == 0));
        check({tag, ".stim_end"},  int'(stim),            valid ? 3 : 0);
        if (valid) begin
            seq_ok = (seq.size() == 4);
            for (int i = 0; i < seq.size() && i < 4; i++) if (seq[i] != i) seq_ok = 1'b0;
            check({tag, ".stim_seq"}, int'(seq_ok), 1);
        end
    endtask

    typedef struct {
        logic [2:0] mode;
        int         kind;
        bit         disturb;
        int         e_err;
        int         e_vld;
        int         e_vec;
        int         e_merr;
        int         e_lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int e_err, e_vld, e_vec, e_merr, e_lat, lat3;
        logic [2:0] rm;

        tbl[0] = '{3'd0, 0, 1'b0, 0, 0, 0, 0, 44};
        tbl[1] = '{3'd1, 1, 1'b0, 3, 1, 1, 0, 44};
        tbl[2] = '{3'd2, 2, 1'b0, 1, 1, 3, 0, 44};
        tbl[3] = '{3'd3, 1, 1'b0, 1, 1, 0, 0, 44};
        tbl[4] = '{3'd4, 2, 1'b0, 2, 1, 0, 0, 44};
        tbl[5] = '{3'd5, 1, 1'b0, 2, 1, 0, 0, 44};
        tbl[6] = '{3'd0, 2, 1'b0, 3, 1, 0, 0, 44};
        tbl[7] = '{3'd7, 0, 1'b0, 0, 0, 0, 1, 0};
        tbl[8] = '{3'd6, 0, 1'b0, 0, 0, 0, 1, 0};
        tbl[9] = '{3'd1, 1, 1'b1, 3, 1, 1, 0, 44};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 3'd0; mode3 = 3'd0;
        gut_kind = 0; gut_mode = 3'd0; resp = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.stim", int'(stim), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.pass", int'(pass), 0);
        check("reset.err",  int'(err_count), 0);
        check("reset.ffvld", int'(first_fail_vld), 0);
        check("reset.merr", int'(mode_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_sweep($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].kind, tbl[i].disturb,
                      tbl[i].e_err, tbl[i].e_vld, tbl[i].e_vec, tbl[i].e_merr, tbl[i].e_lat);
        end

        // Random modes and gate responses against the popcount model.
        for (int r = 0; r < 12; r++) begin
            rm   = 3'($urandom_range(0, 7));
            resp = 4'($urandom);
            e_err = 0; e_vld = 0; e_vec = 0;
            e_merr = (rm > 3'd5) ? 1 : 0;
            e_lat  = e_merr ? 0 : 44;
            if (!e_merr) begin
                for (int v = 0; v < 4; v++) begin
                    if (resp[v] != ref_gate(v, 2, rm)) begin
                        e_err++;
                        if (e_vld == 0) begin e_vld = 1; e_vec = v; end
                    end
                end
            end
            run_sweep($sformatf("rnd%0d", r), rm, 3, 1'b0, e_err, e_vld, e_vec, e_merr, e_lat);
        end

        // Reset during DRIVE of vector 2 abandons the sweep.
        gut_kind = 1; gut_mode = 3'd1; mode = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("midrst.pre_stim", int'(stim), 2);
        check("midrst.pre_err",  int'(err_count), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.stim",  int'(stim), 0);
        check("midrst.busy",  int'(busy), 0);
        check("midrst.done",  int'(done), 0);
        check("midrst.err",   int'(err_count), 0);
        check("midrst.ffvld", int'(first_fail_vld), 0);
        check("midrst.ffvec", int'(first_fail_vec), 0);
        check("midrst.merr",  int'(mode_err), 0);
        @(posedge clk); #1;
        check("midrst.idle_hold", int'(busy), 0);
        run_sweep("after_rst", 3'd1, 1, 1'b0, 3, 1, 1, 0, 44);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; mode = 3'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start.busy", int'(busy), 0);
        check("rst_start.done", int'(done), 0);

        // 3-input XOR against stuck-at-0 with a 2-bit saturating counter.
        mode3 = 3'd4; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat3 = 0;
        while (!done3 && lat3 < 200) begin
            @(posedge clk); #1;
            lat3++;
        end
        check("sat.latency", lat3, 24);
        check("sat.err",     int'(err_count3), 3);
        check("sat.ffvec",   int'(first_fail_vec3), 1);
        check("sat.ffvld",   int'(first_fail_vld3), 1);
        check("sat.pass",    int'(pass3), 0);
        check("sat.stim",    int'(stim3), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
